display_scanner: RTL
====================

# display_scanner

Time-multiplexed controller for the shared seven-segment output. It captures a 32-bit value from the CPU datapath and converts it to BCD with a sequential double-dabble engine. It then scans the digits onto one set of active-low segment lines with one active-low anode per digit. It sits between the CPU's result or debug register and the board's multiplexed seven-segment display.

## Interface
- NUM_DIGITS, 8: number of physical digits; legal range 1..10.
- REFRESH_DIV, 50000: clock cycles each digit stays lit; legal range ≥ 2.
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- value_in  input  32  unsigned binary value to display.
- load  input  1  single-cycle capture strobe for value_in.
- busy  output  1  high while a conversion is in progress or pending.
- segments  output  7  active-low segment bits {g,f,e,d,c,b,a}; registered.
- anodes  output  NUM_DIGITS  active-low digit enables, one-hot-low; bit 0 is the least significant digit; registered.

## Operation
- Decode table, active-low:
  - Digits 0–9: 7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h18.
  - Blank: 7'h7F.
  - Overflow dash: 7'h3F.
- Conversion FSM:
  - IDLE → CONVERT when load=1. Latch value_in into the shift register and clear the 40-bit BCD accumulator.
  - CONVERT runs 32 steps, one per cycle. Each step: add 3 to every BCD nibble ≥ 5, then shift {bcd, bin} left by 1. A 5-bit step counter tracks progress.
  - CONVERT → COMMIT after step 32.
  - COMMIT copies the result into the display register for one cycle, then → IDLE.
- Load during CONVERT or COMMIT: value_in is stored in a pending register and a pending flag is set. Last load wins. On leaving COMMIT with the pending flag set, go directly to CONVERT with the pending value and clear the flag.
- busy = (state != IDLE) | pending.
- Overflow: if any BCD digit at index ≥ NUM_DIGITS is nonzero, COMMIT writes the dash code to every digit.
- Scanner:
  - Refresh counter runs 0..REFRESH_DIV-1.
  - At the terminal count, the digit index increments and wraps NUM_DIGITS-1 → 0.
  - Lit digit gets anodes[i]=0; all other anodes are 1.
  - segments shows the decoded display-register entry for the lit digit.
- The scanner runs continuously and is independent of the conversion FSM. The display register changes only in COMMIT, so no partial value is ever shown.

## Timing
- Reset values:
  - State IDLE, pending flag 0, busy 0.
  - Display register all blank.
  - Refresh counter 0, digit index 0.
  - segments 7'h7F, anodes all 1.
- Load latency: load sampled at edge E0 in IDLE.
  - busy=1 after E0.
  - Steps occur on E1..E32.
  - COMMIT writes the display register at E33; busy=0 after E33 if nothing is pending.
  - Total busy time is 33 cycles.
- segments and anodes are registered one cycle after the digit-index or display-register change.
- Digit index advances every REFRESH_DIV cycles, so a full frame is NUM_DIGITS × REFRESH_DIV cycles.
- Reset asserted mid-conversion aborts the conversion and drops any pending value. All outputs return to reset values at the next edge.
- load and reset in the same cycle: reset wins.
- load in the COMMIT cycle: the value is treated as pending, and the COMMIT in progress still completes.

## Configuration
- DISPLAY_LZB_EN defined: leading-zero blanking. Digits above the most significant nonzero digit show blank (7'h7F). Digit 0 always shows its value, so 0 displays as a single "0".
- DISPLAY_LZB_EN undefined: all NUM_DIGITS digits show their decimal value, including leading zeros. The overflow dash behaviour is the same in both builds.

## Test plan
- Bench configuration for all scenarios: NUM_DIGITS=8, REFRESH_DIV=4.
- Reset, then hold for 40 cycles: segments=7'h7F, anodes cycles 8'hFE→8'hFD→…→8'h7F→8'hFE, each step 4 cycles apart; busy=0.
- load with value_in=1234, LZB on:
  - busy high for exactly 33 cycles.
  - Afterwards digits 0..3 show 7'h19, 7'h30, 7'h24, 7'h79.
  - Digits 4..7 show 7'h7F.
- load with value_in=0:
  - LZB on: digit 0=7'h40, others blank.
  - LZB off: all eight digits show 7'h40.
- load with value_in=100000000: all digits show 7'h3F. Then load 99999999: all digits show 7'h18.
- Loads of 5, then 7 at +3 cycles, then 9 at +10 cycles:
  - First COMMIT shows 5.
  - busy stays high and a second conversion shows 9.
  - 7 never appears.
- Reset asserted at step 16 of a conversion of 4321: outputs return to reset values next cycle; display stays blank and busy=0.

Source files
------------

// File: rtl/display_scanner.sv
// Seven-segment scanner with a sequential double-dabble BCD converter.
// Optional leading-zero blanking: define DISPLAY_LZB_EN.
module display_scanner #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           value_in,
  input  logic                  load,
  output logic                  busy,
  output logic [6:0]            segments,
  output logic [NUM_DIGITS-1:0] anodes
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [RW-1:0] RLAST = RW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0] DLAST = DW'(NUM_DIGITS - 1);

  // Display symbols: 0..9 are digits, the rest are glyphs.
  localparam logic [3:0] SYM_BLANK = 4'hA;
  localparam logic [3:0] SYM_DASH  = 4'hB;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    COMMIT
  } state_t;

  state_t      state;
  state_t      state_nx;

  logic [31:0] bin;
  logic [31:0] bin_nx;
  logic [39:0] bcd;
  logic [39:0] bcd_nx;
  logic [39:0] adj;
  logic [4:0]  step;
  logic [4:0]  step_nx;

  logic        pend;
  logic        pend_nx;
  logic [31:0] pend_val;
  logic [31:0] pend_val_nx;

  logic [3:0]  disp    [NUM_DIGITS];
  logic [3:0]  disp_nx [NUM_DIGITS];
  logic        disp_we;
  logic        ovf;
  logic [3:0]  nib;
`ifdef DISPLAY_LZB_EN
  logic        lead;
`endif

  logic [RW-1:0] rcnt;
  logic [DW-1:0] dig;

  function automatic logic [6:0] decode(input logic [3:0] s);
    logic [6:0] r;
    r = 7'h7F;
    unique case (s)
      4'd0:     r = 7'h40;
      4'd1:     r = 7'h79;
      4'd2:     r = 7'h24;
      4'd3:     r = 7'h30;
      4'd4:     r = 7'h19;
      4'd5:     r = 7'h12;
      4'd6:     r = 7'h02;
      4'd7:     r = 7'h78;
      4'd8:     r = 7'h00;
      4'd9:     r = 7'h18;
      SYM_DASH: r = 7'h3F;
      default:  r = 7'h7F;
    endcase
    return r;
  endfunction

  // Add-3 correction of every BCD nibble before the shift.
  always_comb begin
    adj = bcd;
    for (int i = 0; i < 10; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  // Conversion FSM: next state, datapath updates, pending capture.
  always_comb begin
    state_nx    = state;
    bin_nx      = bin;
    bcd_nx      = bcd;
    step_nx     = step;
    pend_nx     = pend;
    pend_val_nx = pend_val;
    disp_we     = 1'b0;
    unique case (state)
      IDLE: begin
        if (load) begin
          state_nx = CONVERT;
          bin_nx   = value_in;
          bcd_nx   = '0;
          step_nx  = '0;
        end
      end
      CONVERT: begin
        {bcd_nx, bin_nx} = {adj, bin} << 1;
        step_nx = step + 5'd1;
        if (step == 5'd31) begin
          state_nx = COMMIT;
        end
        if (load) begin
          pend_nx     = 1'b1;
          pend_val_nx = value_in;
        end
      end
      COMMIT: begin
        disp_we = 1'b1;
        if (load || pend) begin
          state_nx = CONVERT;
          bin_nx   = load ? value_in : pend_val;
          bcd_nx   = '0;
          step_nx  = '0;
          pend_nx  = 1'b0;
        end else begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Conversion state and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      bin      <= '0;
      bcd      <= '0;
      step     <= '0;
      pend     <= 1'b0;
      pend_val <= '0;
    end else begin
      state    <= state_nx;
      bin      <= bin_nx;
      bcd      <= bcd_nx;
      step     <= step_nx;
      pend     <= pend_nx;
      pend_val <= pend_val_nx;
    end
  end

  assign busy = (state != IDLE) | pend;

  // Symbols committed from the finished BCD result.
  always_comb begin
    ovf = 1'b0;
    nib = '0;
`ifdef DISPLAY_LZB_EN
    lead = 1'b1;
`endif
    for (int i = 0; i < 10; i++) begin
      if (i >= NUM_DIGITS && bcd[4*i +: 4] != 4'd0) begin
        ovf = 1'b1;
      end
    end
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nib = bcd[4*i +: 4];
`ifdef DISPLAY_LZB_EN
      if (nib != 4'd0 || i == 0) begin
        lead = 1'b0;
      end
      disp_nx[i] = ovf ? SYM_DASH : (lead ? SYM_BLANK : nib);
`else
      disp_nx[i] = ovf ? SYM_DASH : nib;
`endif
    end
  end

  // Display register, written only in the commit cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        disp[i] <= SYM_BLANK;
      end
    end else if (disp_we) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        disp[i] <= disp_nx[i];
      end
    end
  end

  // Refresh divider and lit-digit index.
  always_ff @(posedge clk) begin
    if (reset) begin
      rcnt <= '0;
      dig  <= '0;
    end else if (rcnt == RLAST) begin
      rcnt <= '0;
      dig  <= (dig == DLAST) ? '0 : dig + DW'(1);
    end else begin
      rcnt <= rcnt + RW'(1);
    end
  end

  // Registered segment and anode drive for the lit digit.
  always_ff @(posedge clk) begin
    if (reset) begin
      segments <= 7'h7F;
      anodes   <= '1;
    end else begin
      segments <= decode(disp[dig]);
      anodes   <= ~(NUM_DIGITS'(1) << dig);
    end
  end

endmodule
